// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, machine-word width and the
// legality boundary used by both the control decoder and the program loader.
package cpu_pkg;

   localparam int unsigned MCODEBITS = 9;

   typedef enum logic [3:0] {
      OpLoad   = 4'b0000,
      OpStore  = 4'b0001,
      OpXor    = 4'b0010,
      OpBne    = 4'b0011,
      OpAdd    = 4'b0100,
      OpMov    = 4'b0101,
      OpLshift = 4'b0110,
      OpRshift = 4'b0111,
      OpLoadi  = 4'b1000,
      OpPari   = 4'b1001
   } opcode_e;

   localparam logic [3:0] OP_LAST_LEGAL = OpPari;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StFull,
      StDone
   } loader_state_e;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_LAST_LEGAL;
   endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Beat-in / write-out bundle between an instruction source and the loader.
interface instr_loader_if #(
   parameter int unsigned AW        = 10,
   parameter int unsigned MCODEBITS = 9
) ();

   logic                 start;
   logic                 in_valid;
   logic                 in_ready;
   logic [3:0]           in_op;
   logic [4:0]           in_operand;
   logic                 in_last;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [MCODEBITS-1:0] wr_data;
   logic [AW:0]          count;
   logic                 done;
   logic                 full;
   logic                 err_illegal;

   modport master (
      output start, in_valid, in_op, in_operand, in_last,
      input  in_ready, wr_en, wr_addr, wr_data, count, done, full, err_illegal
   );

   modport slave (
      input  start, in_valid, in_op, in_operand, in_last,
      output in_ready, wr_en, wr_addr, wr_data, count, done, full, err_illegal
   );

endinterface

// File: rtl/instr_pack.sv
// Packs opcode and operand into a machine word (inverse of the decoder's
// instr[8:5] split) and flags opcodes beyond the last legal one.
module instr_pack #(
   parameter int unsigned MCODEBITS = cpu_pkg::MCODEBITS
) (
   input  logic [3:0]           op,
   input  logic [4:0]           operand,
   output logic [MCODEBITS-1:0] word,
   output logic                 legal
);
   import cpu_pkg::*;

   always_comb begin
      word  = MCODEBITS'({op, operand});
      legal = op_legal(op);
   end

endmodule

// File: rtl/instr_loader.sv
// Streams encoded instructions into instruction memory from address 0,
// stopping on the last beat or when the address space is exhausted.
module instr_loader #(
   parameter int unsigned AW        = 10,
   parameter int unsigned MCODEBITS = cpu_pkg::MCODEBITS
) (
   input logic          clk,
   input logic          rst_n,
   instr_loader_if.slave bus
);
   import cpu_pkg::*;

   localparam logic [AW-1:0] AddrMax  = '1;
   localparam logic [AW:0]   CountMax = {1'b1, {AW{1'b0}}};

   loader_state_e        state_q, state_d;
   logic [AW-1:0]        addr_q;
   logic [AW:0]          count_q;
   logic                 err_q;
   logic                 wr_en_q;
   logic [AW-1:0]        wr_addr_q;
   logic [MCODEBITS-1:0] wr_data_q;
   logic [MCODEBITS-1:0] word;
   logic                 legal;
   logic                 accept;

   instr_pack #(.MCODEBITS(MCODEBITS)) u_pack (
      .op      (bus.in_op),
      .operand (bus.in_operand),
      .word    (word),
      .legal   (legal)
   );

   // A start in LOAD restarts the load and drops the beat of that cycle.
   assign accept = (state_q == StLoad) && bus.in_valid && !bus.start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StFull, StDone: begin
            if (bus.start) state_d = StLoad;
         end
         StLoad: begin
            if (accept) begin
               if (bus.in_last) begin
                  state_d = StDone;
               end else if (legal && addr_q == AddrMax) begin
                  state_d = StFull;
               end
            end
         end
      endcase
   end

   always_comb begin
      bus.in_ready    = (state_q == StLoad);
      bus.done        = (state_q == StDone);
      bus.full        = (state_q == StFull);
      bus.wr_en       = wr_en_q;
      bus.wr_addr     = wr_addr_q;
      bus.wr_data     = wr_data_q;
      bus.count       = count_q;
      bus.err_illegal = err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= accept && legal;
         if (bus.start) begin
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
         end else if (accept) begin
            if (legal) begin
               wr_addr_q <= addr_q;
               wr_data_q <= word;
               // Address holds at the top; the FSM leaves LOAD instead of wrapping.
               if (addr_q != AddrMax) addr_q <= addr_q + AW'(1);
               if (count_q != CountMax) count_q <= count_q + (AW+1)'(1);
            end else begin
               err_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table, directed corner cases
// and random beats compared against a transaction-level model.
module tb_instr_loader;

   localparam int unsigned AW    = 3;
   localparam int          Depth = 1 << AW;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   instr_loader_if #(.AW(AW), .MCODEBITS(9)) bus ();

   instr_loader #(.AW(AW), .MCODEBITS(9)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors  = 0;
   int checks  = 0;
   int wr_seen = 0;

   // Model: a load session writing consecutive words until last or memory end.
   bit       m_loading, m_done, m_full, m_err, m_pend;
   int       m_addr, m_count, m_paddr;
   logic [8:0] m_pdata;

   typedef struct {
      logic       s;
      logic       v;
      logic [3:0] op;
      logic [4:0] opd;
      logic       l;
      logic       ew;
      int         ea;
      logic [8:0] ed;
      int         ec;
      logic       edone;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_loading = 0; m_done = 0; m_full = 0; m_err = 0; m_pend = 0;
      m_addr = 0; m_count = 0; m_paddr = 0; m_pdata = '0;
   endtask

   task automatic model_step(input logic s, input logic v, input logic [3:0] op,
                             input logic [4:0] opd, input logic l);
      m_pend = 0;
      if (s) begin
         m_loading = 1; m_addr = 0; m_count = 0; m_err = 0; m_done = 0; m_full = 0;
      end else if (m_loading && v) begin
         if (op <= 4'd9) begin
            m_pend  = 1;
            m_paddr = m_addr;
            m_pdata = {op, opd};
            m_addr++;
            if (m_count < Depth) m_count++;
         end else begin
            m_err = 1;
         end
         if (l) begin
            m_loading = 0; m_done = 1;
         end else if (op <= 4'd9 && m_addr == Depth) begin
            m_loading = 0; m_full = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("in_ready", bus.in_ready, m_loading);
      chk("wr_en", bus.wr_en, m_pend);
      if (m_pend) begin
         chk("wr_addr", bus.wr_addr, m_paddr);
         chk("wr_data", bus.wr_data, m_pdata);
      end
      chk("count", bus.count, m_count);
      chk("done", bus.done, m_done);
      chk("full", bus.full, m_full);
      chk("err_illegal", bus.err_illegal, m_err);
   endtask

   // Called at a falling edge: drive, clock once, check at the next falling edge.
   task automatic step(input logic s, input logic v, input logic [3:0] op,
                       input logic [4:0] opd, input logic l);
      bus.start = s; bus.in_valid = v; bus.in_op = op; bus.in_operand = opd; bus.in_last = l;
      model_step(s, v, op, opd, l);
      @(negedge clk);
      check_all();
      if (bus.wr_en) wr_seen++;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_wr_en"}, bus.wr_en, 0);
      chk({tag, "_wr_addr"}, bus.wr_addr, 0);
      chk({tag, "_wr_data"}, bus.wr_data, 0);
      chk({tag, "_count"}, bus.count, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_full"}, bus.full, 0);
      chk({tag, "_err"}, bus.err_illegal, 0);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 0, 9'h000, 0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 4'd4, 5'd5, 1'b0, 1'b1, 0, 9'h085, 1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 4'd2, 5'd3, 1'b0, 1'b1, 1, 9'h043, 2, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 4'd3, 5'd1, 1'b1, 1'b1, 2, 9'h061, 3, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 0, 9'h000, 3, 1'b1};

      bus.start = 0; bus.in_valid = 0; bus.in_op = '0; bus.in_operand = '0; bus.in_last = 0;
      model_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #11 check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Three-instruction program from the vector table
      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].v, tbl[i].op, tbl[i].opd, tbl[i].l);
         chk("tbl_wr_en", bus.wr_en, tbl[i].ew);
         if (tbl[i].ew) begin
            chk("tbl_wr_addr", bus.wr_addr, tbl[i].ea);
            chk("tbl_wr_data", bus.wr_data, tbl[i].ed);
         end
         chk("tbl_count", bus.count, tbl[i].ec);
         chk("tbl_done", bus.done, tbl[i].edone);
      end

      // Re-arm from DONE with a single loadi
      step(1, 0, 0, 0, 0);
      chk("rearm_done_clr", bus.done, 0);
      step(0, 1, 4'd8, 5'd31, 1);
      chk("rearm_wr_data", bus.wr_data, 9'h11F);
      chk("rearm_wr_addr", bus.wr_addr, 0);
      step(0, 0, 0, 0, 0);
      chk("rearm_done", bus.done, 1);

      // Illegal opcode dropped, following legal beat written to address 0
      step(1, 0, 0, 0, 0);
      wr_seen = 0;
      step(0, 1, 4'b1100, 5'd7, 0);
      chk("illegal_err", bus.err_illegal, 1);
      step(0, 1, 4'd5, 5'd2, 1);
      chk("illegal_wr_data", bus.wr_data, 9'h0A2);
      chk("illegal_wr_addr", bus.wr_addr, 0);
      step(0, 0, 0, 0, 0);
      chk("illegal_count", bus.count, 1);
      chk("illegal_writes", wr_seen, 1);

      // Start during LOAD discards the concurrent beat and restarts at 0
      step(1, 0, 0, 0, 0);
      step(0, 1, 4'd4, 5'd1, 0);
      step(1, 1, 4'd5, 5'd9, 0);
      chk("restart_no_wr", bus.wr_en, 0);
      chk("restart_count", bus.count, 0);
      step(0, 1, 4'd6, 5'd4, 0);
      chk("restart_wr_addr", bus.wr_addr, 0);
      chk("restart_wr_data", bus.wr_data, 9'h0C4);

      // Fill all 8 words without last; a 9th beat must be refused
      step(1, 0, 0, 0, 0);
      wr_seen = 0;
      for (int i = 0; i < Depth; i++) step(0, 1, 4'd5, 5'(i), 0);
      chk("fill_last_addr", bus.wr_addr, Depth - 1);
      chk("fill_full", bus.full, 1);
      chk("fill_in_ready", bus.in_ready, 0);
      step(0, 1, 4'd5, 5'd9, 0);
      chk("fill_9th_no_wr", bus.wr_en, 0);
      chk("fill_writes", wr_seen, Depth);
      chk("fill_count", bus.count, Depth);

      // Last on the top address: DONE wins over FULL
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < Depth - 1; i++) step(0, 1, 4'd1, 5'(i), 0);
      step(0, 1, 4'd1, 5'd7, 1);
      chk("top_last_done", bus.done, 1);
      chk("top_last_full", bus.full, 0);
      chk("top_last_count", bus.count, Depth);

      // Random beats against the model
      for (int n = 0; n < 400; n++) begin
         step(logic'($urandom_range(0, 15) == 0), logic'($urandom_range(0, 3) != 0),
              4'($urandom_range(0, 11)), 5'($urandom), logic'($urandom_range(0, 9) == 0));
      end

      // Asynchronous reset mid-load with in_valid held
      step(1, 0, 0, 0, 0);
      step(0, 1, 4'd4, 5'd3, 0);
      step(0, 1, 4'd7, 5'd6, 0);
      chk("pre_reset_wr_en", bus.wr_en, 1);
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("in_reset_wr_en", bus.wr_en, 0);
      end
      rst_n = 1'b1;
      step(0, 1, 4'd7, 5'd6, 0);
      step(0, 1, 4'd7, 5'd6, 0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 4'd9, 5'd21, 1);
      step(0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter AW, default 10, instruction-memory address width.
REQ-002 Parameter MCODEBITS, default 9, machine-word width.
REQ-003 Clk  input  1  sole clock, all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse, arms a new program load from address 0.
REQ-006 in_valid  input  1  source presents an instruction beat.
REQ-007 in_ready  output  1  loader accepts a beat this cycle.
REQ-008 in_op  input  4  mnemonic opcode: load 0000, store 0001, xor 0010, bne 0011, add 0100, mov 0101, lshift 0110, rshift 0111, loadi 1000, pari 1001.
REQ-009 in_operand  input  5  register/immediate field.
REQ-010 in_last  input  1  beat is the final instruction of the program.
REQ-011 wr_en  output  1  instruction-memory write strobe.
REQ-012 wr_addr  output  AW  instruction-memory write address.
REQ-013 wr_data  output  MCODEBITS  encoded machine word.
REQ-014 count  output  AW+1  number of words written this load.
REQ-015 done  output  1  load completed via in_last.
REQ-016 full  output  1  address space exhausted before in_last.
REQ-017 err_illegal  output  1  sticky, an illegal opcode beat was dropped.

Function
REQ-018 Encoding SHALL be wr_data[8:5]=in_op and wr_data[4:0]=in_operand, giving the inverse of the control decoder's instr[8:5] field split.
REQ-019 Opcodes 1010-1111 SHALL be illegal: the beat is consumed, nothing is written, address and count are unchanged, and err_illegal is set.
REQ-020 The FSM SHALL have the states IDLE, LOAD, FULL, and DONE; reset enters IDLE.
REQ-021 IDLE: in_ready=0; start -> LOAD, clearing the address, count, and err_illegal.
REQ-022 LOAD: in_ready=1; a beat is accepted when in_valid&&in_ready.
REQ-023 A legal accepted beat SHALL produce wr_en=1 on the next cycle, registered, with wr_addr equal to the pre-increment address; latency is exactly 1 cycle; the address increments by 1.
REQ-024 An accepted beat with in_last (legal or illegal) SHALL cause LOAD -> DONE; the final write, if legal, still issues.
REQ-025 A legal write to address 2^AW-1 without in_last SHALL cause LOAD -> FULL; no address wrap occurs.
REQ-026 If the beat written to 2^AW-1 carries in_last, DONE SHALL take priority over FULL.
REQ-027 In FULL and DONE, in_ready SHALL be 0 and the done/full levels SHALL be held; start -> LOAD (re-arm).
REQ-028 A start while in LOAD SHALL restart at address 0 and discard any beat presented in that cycle.
REQ-029 wr_en SHALL be a single-cycle pulse per legal beat; back-to-back beats yield back-to-back writes.
REQ-030 count SHALL saturate at 2^AW.

Reset
REQ-031 Reset low SHALL asynchronously force IDLE, wr_en=0, wr_addr=0, wr_data=0, count=0, done=0, full=0, err_illegal=0, in_ready=0.
REQ-032 Reset mid-load SHALL abandon the load; no write strobe issues after reset asserts.

Structure
REQ-033 cpu_pkg SHALL hold the opcode enum (LOAD..PARI), MCODEBITS, and the OP_LAST_LEGAL constant shared with the control decoder.
REQ-034 A combinational sub-module instr_pack SHALL perform field packing and the legality check; instr_loader holds the FSM, address counter, and output registers.

Verification
REQ-035 The bench SHALL check that start, then beats {add,5}, {xor,3}, {bne,1,last}, produce writes 0x085@0, 0x043@1, 0x061@2, then done=1 and count=3.
REQ-036 The bench SHALL check that start, then {op=1100} followed by {mov,2,last}, produce err_illegal=1 and exactly one write, 0x0A2@0, with count=1.
REQ-037 The bench SHALL check that, with AW=3, 9 beats without last produce 8 writes, full=1 after address 7, in_ready=0, and a 9th beat that is not accepted.
REQ-038 The bench SHALL check that, with AW=3, an 8th beat carrying last produces done=1 and full=0.
REQ-039 The bench SHALL check that Reset asserted asynchronously mid-LOAD with in_valid held gives all outputs zero immediately and no further wr_en pulses.
REQ-040 The bench SHALL check that start in DONE, followed by {loadi,31,last}, produces 0x11F@0 and done re-asserted.
